// File: rtl/audio_out_streamer.sv
// audio_out_streamer
//
// Captures 128-bit vector stores aimed at OUT_BASE into a small FIFO and
// plays them out one SAMPLE_W-bit lane per sample-rate tick over a
// valid/ready handshake toward the DAC. Lane 0 of a vector goes out first;
// the vector is popped once its last lane has been emitted.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   reset         synchronous, active-low; clears every register
//   enable        1 = tick counter runs and samples are emitted
//   wren_b        vector store strobe from the processor
//   addr_b        vector store address; only OUT_BASE is accepted
//   data_b        vector store data; lane k = data_b[SAMPLE_W*k +: SAMPLE_W]
//   stall_req     FIFO full (level == DEPTH), combinational
//   sample_out    current sample toward the DAC
//   sample_valid  sample_out holds an unconsumed sample
//   sample_ready  DAC accepts the sample when valid && ready
//   fifo_level    number of vectors stored
//   status        sticky {late, underrun, overflow}
//   clear_status  synchronous clear of status; a same-cycle set wins

module audio_out_streamer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned TICK_DIV = 1042,
    parameter logic [31:0] OUT_BASE = 32'h0000_0400
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         wren_b,
    input  logic [31:0]                  addr_b,
    input  logic [127:0]                 data_b,
    output logic                         stall_req,
    output logic [SAMPLE_W-1:0]          sample_out,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [2:0]                   status,
    input  logic                         clear_status
);

    localparam int unsigned LANES  = 128 / SAMPLE_W;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W  = $clog2(TICK_DIV);

    // Status bit positions
    localparam int unsigned StOverflow = 0;
    localparam int unsigned StUnderrun = 1;
    localparam int unsigned StLate     = 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [127:0]          mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic [2:0]            status_q, status_d;

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    logic                  addr_hit;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  push_drop;
    logic                  tick;
    logic                  slot_free;
    logic                  emit;
    logic                  pop;
    logic                  underrun_ev;
    logic                  late_ev;
    logic [LANES-1:0][SAMPLE_W-1:0] head_vec;
    logic [SAMPLE_W-1:0]   head_lane;

    always_comb begin
        addr_hit    = wren_b && (addr_b == OUT_BASE);
        full        = (level_q == LVL_W'(DEPTH));
        empty       = (level_q == '0);
        // Acceptance uses the pre-edge level, so a full FIFO rejects a store
        // even if it pops on the same edge.
        push        = addr_hit && !full;
        push_drop   = addr_hit && full;
        tick        = enable && (cnt_q == CNT_W'(TICK_DIV - 1));
        // The output register may be reloaded if it is empty or being drained
        // on this very edge.
        slot_free   = !valid_q || sample_ready;
        emit        = tick && slot_free && !empty;
        pop         = emit && (lane_q == LANE_W'(LANES - 1));
        underrun_ev = tick && slot_free && empty;
        late_ev     = tick && !slot_free;
    end

    // Reinterpret the head vector as an array of lanes for selection.
    always_comb begin
        head_vec  = mem_q[rd_ptr_q];
        head_lane = head_vec[lane_q];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        lane_d   = lane_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (emit) begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                lane_d   = '0;
            end else begin
                lane_d   = lane_q + LANE_W'(1);
            end
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        sample_d = sample_q;
        valid_d  = valid_q;

        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        if (emit) begin
            sample_d = head_lane;
            valid_d  = 1'b1;
        end else if (underrun_ev) begin
            // sample_out keeps the last value; only valid drops.
            valid_d = 1'b0;
        end
    end

    always_comb begin
        status_d = clear_status ? 3'b000 : status_q;
        if (push_drop) begin
            status_d[StOverflow] = 1'b1;
        end
        if (underrun_ev) begin
            status_d[StUnderrun] = 1'b1;
        end
        if (late_ev) begin
            status_d[StLate] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            lane_q   <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            status_q <= 3'b000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            lane_q   <= lane_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            status_q <= status_d;
        end
    end

    // Storage needs no reset: after reset the level is zero, so no stale
    // entry is ever read out.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= data_b;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        stall_req    = full;
        sample_out   = sample_q;
        sample_valid = valid_q;
        fifo_level   = level_q;
        status       = status_q;
    end

endmodule

// File: tb/tb_audio_out_streamer.sv
module tb_audio_out_streamer;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam logic [31:0] OUT_BASE = 32'h0000_0400;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         wren_b;
    logic [31:0]  addr_b;
    logic [127:0] data_b;
    logic         stall_req;
    logic [15:0]  sample_out;
    logic         sample_valid;
    logic         sample_ready;
    logic [2:0]   fifo_level;
    logic [2:0]   status;
    logic         clear_status;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb [$];
    time         hs_times [$];
    logic [15:0] mon_exp;

    audio_out_streamer #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SAMPLE_W),
        .TICK_DIV (TICK_DIV),
        .OUT_BASE (OUT_BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .wren_b       (wren_b),
        .addr_b       (addr_b),
        .data_b       (data_b),
        .stall_req    (stall_req),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_level   (fifo_level),
        .status       (status),
        .clear_status (clear_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [127:0] mk_vec(input logic [15:0] base);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = base + 16'(k);
        return v;
    endfunction

    task automatic enqueue(input logic [15:0] base);
        for (int k = 0; k < 8; k++) sb.push_back(base + 16'(k));
    endtask

    // One-cycle store; caller is positioned just after a rising edge.
    task automatic store(input logic [31:0] addr, input logic [15:0] base);
        wren_b = 1'b1;
        addr_b = addr;
        data_b = mk_vec(base);
        step(1);
        wren_b = 1'b0;
        addr_b = '0;
        data_b = '0;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
    endtask

    // Scoreboard monitor: every accepted sample must match the queue head.
    always @(negedge clk) begin
        if (reset && sample_valid && sample_ready) begin
            hs_times.push_back($time);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got %0h expected none", sample_out);
            end else begin
                mon_exp = sb.pop_front();
                check("sample", {112'b0, sample_out}, {112'b0, mon_exp});
            end
        end
    end

    initial begin
        reset        = 1'b0;
        enable       = 1'b0;
        wren_b       = 1'b0;
        addr_b       = '0;
        data_b       = '0;
        sample_ready = 1'b1;
        clear_status = 1'b0;
        step(2);
        reset = 1'b1;

        // Reset state
        check("rst_level", fifo_level, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_sample", sample_out, 0);
        check("rst_status", status, 0);
        check("rst_stall", stall_req, 0);

        // Single vector, lanes 1..8, one sample every 4 cycles
        hs_times.delete();
        store(OUT_BASE, 16'h0001);
        enqueue(16'h0001);
        check("t1_level_push", fifo_level, 1);
        enable = 1'b1;
        step(31);
        check("t1_level_before_pop", fifo_level, 1);
        step(1);
        check("t1_level_after_pop", fifo_level, 0);
        check("t1_status", status, 3'b000);
        enable = 1'b0;
        step(1);
        check("t1_count", hs_times.size(), 8);
        for (int i = 1; i < 8; i++) begin
            if (i < hs_times.size()) begin
                check("t1_spacing", 128'(hs_times[i] - hs_times[i-1]), 40);
            end
        end

        // Store to another address is ignored
        store(OUT_BASE + 32'd16, 16'h0BAD);
        check("t2_level", fifo_level, 0);
        check("t2_status", status, 3'b000);

        // Five back-to-back stores: the fifth overflows
        store(OUT_BASE, 16'h1100);
        store(OUT_BASE, 16'h1200);
        store(OUT_BASE, 16'h1300);
        store(OUT_BASE, 16'h1400);
        store(OUT_BASE, 16'hEE00);
        enqueue(16'h1100);
        enqueue(16'h1200);
        enqueue(16'h1300);
        enqueue(16'h1400);
        check("t3_level", fifo_level, 4);
        check("t3_stall", stall_req, 1);
        check("t3_status", status, 3'b001);
        enable = 1'b1;
        step(31);
        check("t3_stall_before_pop", stall_req, 1);
        step(1);
        check("t3_level_after_pop", fifo_level, 3);
        check("t3_stall_after_pop", stall_req, 0);
        step(96);
        check("t3_level_drained", fifo_level, 0);
        enable = 1'b0;
        check("t3_status_end", status, 3'b001);
        pulse_clear();
        check("t3_cleared", status, 3'b000);

        // Underrun on empty FIFO; clear vs coinciding tick
        enable = 1'b1;
        step(4);
        check("t4_underrun", status, 3'b010);
        check("t4_valid", sample_valid, 0);
        pulse_clear();
        check("t4_clear", status, 3'b000);
        step(2);
        pulse_clear();
        check("t4_set_wins", status, 3'b010);
        enable = 1'b0;
        pulse_clear();
        check("t4_clear2", status, 3'b000);

        // DAC not ready across two ticks: late, lane holds
        store(OUT_BASE, 16'hA000);
        enqueue(16'hA000);
        sample_ready = 1'b0;
        enable = 1'b1;
        step(12);
        check("t5_hold_sample", sample_out, 16'hA000);
        check("t5_hold_valid", sample_valid, 1);
        check("t5_late", status, 3'b100);
        check("t5_level", fifo_level, 1);
        sample_ready = 1'b1;
        step(4);
        check("t5_lane1", sample_out, 16'hA001);
        check("t5_lane1_valid", sample_valid, 1);
        step(24);
        check("t5_level_end", fifo_level, 0);
        enable = 1'b0;
        check("t5_status_end", status, 3'b100);
        pulse_clear();

        // Store on the same edge as the lane-7 pop while full
        store(OUT_BASE, 16'h3000);
        store(OUT_BASE, 16'h3100);
        store(OUT_BASE, 16'h3200);
        store(OUT_BASE, 16'h3300);
        enqueue(16'h3000);
        enqueue(16'h3100);
        enqueue(16'h3200);
        enqueue(16'h3300);
        check("t6_full", fifo_level, 4);
        enable = 1'b1;
        step(31);
        store(OUT_BASE, 16'h3400);
        check("t6_level", fifo_level, 3);
        check("t6_overflow", status, 3'b001);
        check("t6_stall", stall_req, 0);

        // Reset mid-vector discards everything
        step(6);
        reset  = 1'b0;
        enable = 1'b0;
        sb.delete();
        step(1);
        reset = 1'b1;
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_valid", sample_valid, 0);
        check("t6_rst_sample", sample_out, 0);
        check("t6_rst_status", status, 0);
        check("t6_rst_stall", stall_req, 0);
        store(OUT_BASE, 16'h5000);
        enqueue(16'h5000);
        enable = 1'b1;
        step(32);
        check("t6_restart_level", fifo_level, 0);
        enable = 1'b0;
        step(2);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
